// File: rtl/ddr5_bank_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ddr5_bank_sequencer_if: request/command/response bundle of the sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
interface ddr5_bank_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_bg;
  logic [1:0]  req_bank;
  logic [15:0] req_row;
  logic [9:0]  req_col;
  logic        req_write;
  logic [3:0]  cmd;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        rsp_valid;
  logic        rsp_write;

  modport master (
    output req_valid, req_bg, req_bank, req_row, req_col, req_write,
    input  req_ready, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col, rsp_valid, rsp_write
  );

  modport slave (
    input  req_valid, req_bg, req_bank, req_row, req_col, req_write,
    output req_ready, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col, rsp_valid, rsp_write
  );
endinterface
`default_nettype wire

// File: rtl/ddr5_bank_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ddr5_bank_sequencer: in-order DDR5 PRE/ACT/CAS sequencer, 8 BG x 4 banks
// Rev 1.0
// ----------------------------------------------------------------------------
module ddr5_bank_sequencer #(
  parameter int unsigned TRCD   = 8,
  parameter int unsigned TRP    = 8,
  parameter int unsigned TRAS   = 16,
  parameter int unsigned TRTP   = 4,
  parameter int unsigned TWRP   = 12,
  parameter int unsigned TRRD_L = 4,
  parameter int unsigned TRRD_S = 2,
  parameter int unsigned TCCD_L = 6,
  parameter int unsigned TCCD_S = 4
) (
  input wire logic             clock,
  input wire logic             reset_n,
  ddr5_bank_sequencer_if.slave bus
);

  localparam logic [7:0] c_trcd_m1 = 8'(TRCD - 1);
  localparam logic [7:0] c_trp_m1  = 8'(TRP - 1);
  localparam logic [7:0] c_tras_m1 = 8'(TRAS - 1);
  localparam logic [7:0] c_trtp_m1 = 8'(TRTP - 1);
  localparam logic [7:0] c_twrp_m1 = 8'(TWRP - 1);
  localparam logic [7:0] c_trrd_l  = 8'(TRRD_L);
  localparam logic [7:0] c_trrd_s  = 8'(TRRD_S);
  localparam logic [7:0] c_tccd_l  = 8'(TCCD_L);
  localparam logic [7:0] c_tccd_s  = 8'(TCCD_S);

  localparam logic [3:0] c_cmd_null = 4'd0;
  localparam logic [3:0] c_cmd_act0 = 4'd1;
  localparam logic [3:0] c_cmd_act1 = 4'd2;
  localparam logic [3:0] c_cmd_rd0  = 4'd3;
  localparam logic [3:0] c_cmd_rd1  = 4'd4;
  localparam logic [3:0] c_cmd_wr0  = 4'd5;
  localparam logic [3:0] c_cmd_wr1  = 4'd6;
  localparam logic [3:0] c_cmd_pre  = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_ACT0 = 3'd2,
    ST_ACT1 = 3'd3,
    ST_CAS0 = 3'd4,
    ST_CAS1 = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  bg_q;
  logic [1:0]  bank_q;
  logic [15:0] row_q;
  logic [9:0]  col_q;
  logic        write_q;

  logic        open_q     [32];
  logic        open_d     [32];
  logic [15:0] open_row_q [32];
  logic [15:0] open_row_d [32];
  logic [7:0]  rcd_cnt_q  [32];
  logic [7:0]  rcd_cnt_d  [32];
  logic [7:0]  rp_cnt_q   [32];
  logic [7:0]  rp_cnt_d   [32];
  logic [7:0]  pre_cnt_q  [32];
  logic [7:0]  pre_cnt_d  [32];

  logic [2:0]  last_act_bg_q, last_act_bg_d;
  logic [2:0]  last_cas_bg_q, last_cas_bg_d;
  logic [7:0]  act_elapsed_q, act_elapsed_d;
  logic [7:0]  cas_elapsed_q, cas_elapsed_d;

  logic [4:0]  w_idx;
  logic [4:0]  w_req_idx;
  logic        w_act_gap_ok;
  logic        w_cas_gap_ok;
  logic        w_pre_issue;
  logic        w_act_issue;
  logic        w_cas_issue;
  logic        w_req_ready;
  logic [3:0]  w_cmd;
  logic [2:0]  w_cmd_bg;
  logic [1:0]  w_cmd_bank;
  logic [15:0] w_cmd_row;
  logic [9:0]  w_cmd_col;
  logic        w_rsp_valid;
  logic        w_rsp_write;

  function automatic logic [7:0] dec_sat(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  assign w_idx        = {bg_q, bank_q};
  assign w_req_idx    = {bus.req_bg, bus.req_bank};
  assign w_act_gap_ok = act_elapsed_q >= ((bg_q == last_act_bg_q) ? c_trrd_l : c_trrd_s);
  assign w_cas_gap_ok = cas_elapsed_q >= ((bg_q == last_cas_bg_q) ? c_tccd_l : c_tccd_s);

  always_comb begin
    state_d     = state_q;
    w_pre_issue = 1'b0;
    w_act_issue = 1'b0;
    w_cas_issue = 1'b0;
    w_req_ready = 1'b0;
    w_cmd       = c_cmd_null;
    w_cmd_bg    = 3'd0;
    w_cmd_bank  = 2'd0;
    w_cmd_row   = 16'd0;
    w_cmd_col   = 10'd0;
    w_rsp_valid = 1'b0;
    w_rsp_write = 1'b0;
    case (state_q)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          if (open_q[w_req_idx] && (open_row_q[w_req_idx] == bus.req_row)) state_d = ST_CAS0;
          else if (open_q[w_req_idx])                                      state_d = ST_PRE;
          else                                                             state_d = ST_ACT0;
        end
      end
      ST_PRE: begin
        if (pre_cnt_q[w_idx] == 8'd0) begin
          w_pre_issue = 1'b1;
          w_cmd       = c_cmd_pre;
          w_cmd_bg    = bg_q;
          w_cmd_bank  = bank_q;
          state_d     = ST_ACT0;
        end
      end
      ST_ACT0: begin
        if ((rp_cnt_q[w_idx] == 8'd0) && w_act_gap_ok) begin
          w_act_issue = 1'b1;
          w_cmd       = c_cmd_act0;
          w_cmd_bg    = bg_q;
          w_cmd_bank  = bank_q;
          w_cmd_row   = row_q;
          state_d     = ST_ACT1;
        end
      end
      ST_ACT1: begin
        w_cmd      = c_cmd_act1;
        w_cmd_bg   = bg_q;
        w_cmd_bank = bank_q;
        w_cmd_row  = row_q;
        state_d    = ST_CAS0;
      end
      ST_CAS0: begin
        if ((rcd_cnt_q[w_idx] == 8'd0) && w_cas_gap_ok) begin
          w_cas_issue = 1'b1;
          w_cmd       = write_q ? c_cmd_wr0 : c_cmd_rd0;
          w_cmd_bg    = bg_q;
          w_cmd_bank  = bank_q;
          w_cmd_col   = col_q;
          state_d     = ST_CAS1;
        end
      end
      ST_CAS1: begin
        w_cmd       = write_q ? c_cmd_wr1 : c_cmd_rd1;
        w_cmd_bg    = bg_q;
        w_cmd_bank  = bank_q;
        w_cmd_col   = col_q;
        w_rsp_valid = 1'b1;
        w_rsp_write = write_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Every bank's timers run each cycle; only the addressed bank is reloaded on issue.
  // pre_cnt keeps the later of the running bound and the new one.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      open_d[i]     = open_q[i];
      open_row_d[i] = open_row_q[i];
      rcd_cnt_d[i]  = dec_sat(rcd_cnt_q[i]);
      rp_cnt_d[i]   = dec_sat(rp_cnt_q[i]);
      pre_cnt_d[i]  = dec_sat(pre_cnt_q[i]);
      if (5'(i) == w_idx) begin
        if (w_pre_issue) begin
          open_d[i]   = 1'b0;
          rp_cnt_d[i] = c_trp_m1;
        end
        if (w_act_issue) begin
          open_d[i]     = 1'b1;
          open_row_d[i] = row_q;
          rcd_cnt_d[i]  = c_trcd_m1;
          pre_cnt_d[i]  = max8(dec_sat(pre_cnt_q[i]), c_tras_m1);
        end
        if (w_cas_issue) begin
          pre_cnt_d[i] = max8(dec_sat(pre_cnt_q[i]), write_q ? c_twrp_m1 : c_trtp_m1);
        end
      end
    end
  end

  // Elapsed trackers count the issue cycle itself as 0, so they read 1 on the next cycle.
  always_comb begin
    last_act_bg_d = w_act_issue ? bg_q : last_act_bg_q;
    last_cas_bg_d = w_cas_issue ? bg_q : last_cas_bg_q;
    act_elapsed_d = w_act_issue ? 8'd1
                  : ((act_elapsed_q == 8'd255) ? 8'd255 : act_elapsed_q + 8'd1);
    cas_elapsed_d = w_cas_issue ? 8'd1
                  : ((cas_elapsed_q == 8'd255) ? 8'd255 : cas_elapsed_q + 8'd1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      bg_q          <= 3'd0;
      bank_q        <= 2'd0;
      row_q         <= 16'd0;
      col_q         <= 10'd0;
      write_q       <= 1'b0;
      last_act_bg_q <= 3'd0;
      last_cas_bg_q <= 3'd0;
      act_elapsed_q <= 8'd255;
      cas_elapsed_q <= 8'd255;
      for (int i = 0; i < 32; i++) begin
        open_q[i]     <= 1'b0;
        open_row_q[i] <= 16'd0;
        rcd_cnt_q[i]  <= 8'd0;
        rp_cnt_q[i]   <= 8'd0;
        pre_cnt_q[i]  <= 8'd0;
      end
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && bus.req_valid) begin
        bg_q    <= bus.req_bg;
        bank_q  <= bus.req_bank;
        row_q   <= bus.req_row;
        col_q   <= bus.req_col;
        write_q <= bus.req_write;
      end
      last_act_bg_q <= last_act_bg_d;
      last_cas_bg_q <= last_cas_bg_d;
      act_elapsed_q <= act_elapsed_d;
      cas_elapsed_q <= cas_elapsed_d;
      for (int i = 0; i < 32; i++) begin
        open_q[i]     <= open_d[i];
        open_row_q[i] <= open_row_d[i];
        rcd_cnt_q[i]  <= rcd_cnt_d[i];
        rp_cnt_q[i]   <= rp_cnt_d[i];
        pre_cnt_q[i]  <= pre_cnt_d[i];
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.cmd       = w_cmd;
  assign bus.cmd_bg    = w_cmd_bg;
  assign bus.cmd_bank  = w_cmd_bank;
  assign bus.cmd_row   = w_cmd_row;
  assign bus.cmd_col   = w_cmd_col;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_write = w_rsp_write;

endmodule
`default_nettype wire

// File: tb/tb_ddr5_bank_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ddr5_bank_sequencer: directed requests checked against a timestamp model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ddr5_bank_sequencer;
  localparam int TRCD = 8, TRP = 8, TRAS = 16, TRTP = 4, TWRP = 12;
  localparam int TRRD_L = 4, TRRD_S = 2, TCCD_L = 6, TCCD_S = 4;
  localparam int NCYC = 4096;
  localparam int NEVER = -1000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  ddr5_bank_sequencer_if bus_if ();

  ddr5_bank_sequencer #(
    .TRCD(TRCD), .TRP(TRP), .TRAS(TRAS), .TRTP(TRTP), .TWRP(TWRP),
    .TRRD_L(TRRD_L), .TRRD_S(TRRD_S), .TCCD_L(TCCD_L), .TCCD_S(TCCD_S)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus_if.slave)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  int rsp_seen = 0;
  bit checking = 1'b0;

  // expected outputs per cycle
  logic [3:0]  e_cmd  [NCYC];
  logic [2:0]  e_bg   [NCYC];
  logic [1:0]  e_bank [NCYC];
  logic [15:0] e_row  [NCYC];
  logic [9:0]  e_col  [NCYC];
  bit          e_rdy  [NCYC];
  bit          e_rsp  [NCYC];
  bit          e_rspw [NCYC];

  // model: earliest legal cycle of each dependent command
  bit          m_open   [32];
  logic [15:0] m_row    [32];
  int          m_act_ok [32];
  int          m_pre_ok [32];
  int          m_cas_ok [32];
  int          m_last_act, m_last_act_bg, m_last_cas, m_last_cas_bg;
  int          free_cyc;

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic clear_from(input int c);
    for (int i = c; i < NCYC; i++) begin
      e_cmd[i] = 4'd0; e_bg[i] = 3'd0; e_bank[i] = 2'd0; e_row[i] = 16'd0; e_col[i] = 10'd0;
      e_rdy[i] = 1'b1; e_rsp[i] = 1'b0; e_rspw[i] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_open[i] = 1'b0; m_row[i] = 16'd0;
      m_act_ok[i] = NEVER; m_pre_ok[i] = NEVER; m_cas_ok[i] = NEVER;
    end
    m_last_act = NEVER; m_last_act_bg = 0;
    m_last_cas = NEVER; m_last_cas_bg = 0;
  endtask

  task automatic put(input int c, input logic [3:0] cm, input logic [2:0] bg, input logic [1:0] bk,
                     input logic [15:0] row, input logic [9:0] col);
    if (c >= 0 && c < NCYC) begin
      e_cmd[c] = cm; e_bg[c] = bg; e_bank[c] = bk; e_row[c] = row; e_col[c] = col;
    end
  endtask

  task automatic check_lit(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Present one request when the model says the sequencer is free; returns the
  // acceptance cycle and the model's PRE/ACT0/CAS0 cycles (-1 when absent).
  task automatic submit(input logic [2:0] bg, input logic [1:0] bk, input logic [15:0] row,
                        input logic [9:0] col, input bit w,
                        output int t, output int tp, output int ta, output int tc);
    int bi, n;
    t = mx(cyc, free_cyc);
    while (cyc < t) @(negedge clock);
    bus_if.req_valid = 1'b1; bus_if.req_bg = bg; bus_if.req_bank = bk;
    bus_if.req_row = row; bus_if.req_col = col; bus_if.req_write = w;
    bi = int'(bg) * 4 + int'(bk);
    n = t + 1; tp = -1; ta = -1;
    if (!(m_open[bi] && m_row[bi] == row)) begin
      if (m_open[bi]) begin
        tp = mx(n, m_pre_ok[bi]);
        put(tp, 4'd7, bg, bk, 16'd0, 10'd0);
        m_open[bi] = 1'b0;
        m_act_ok[bi] = tp + TRP;
        n = tp + 1;
      end
      ta = mx(mx(n, m_act_ok[bi]), m_last_act + ((int'(bg) == m_last_act_bg) ? TRRD_L : TRRD_S));
      put(ta, 4'd1, bg, bk, row, 10'd0);
      put(ta + 1, 4'd2, bg, bk, row, 10'd0);
      m_open[bi] = 1'b1; m_row[bi] = row;
      m_cas_ok[bi] = ta + TRCD;
      m_pre_ok[bi] = mx(m_pre_ok[bi], ta + TRAS);
      m_last_act = ta; m_last_act_bg = int'(bg);
      n = ta + 2;
    end
    tc = mx(mx(n, m_cas_ok[bi]), m_last_cas + ((int'(bg) == m_last_cas_bg) ? TCCD_L : TCCD_S));
    put(tc, w ? 4'd5 : 4'd3, bg, bk, 16'd0, col);
    put(tc + 1, w ? 4'd6 : 4'd4, bg, bk, 16'd0, col);
    if (tc + 1 < NCYC) begin e_rsp[tc + 1] = 1'b1; e_rspw[tc + 1] = w; end
    for (int c = t + 1; c <= tc + 1 && c < NCYC; c++) e_rdy[c] = 1'b0;
    m_pre_ok[bi] = mx(m_pre_ok[bi], tc + (w ? TWRP : TRTP));
    m_last_cas = tc; m_last_cas_bg = int'(bg);
    free_cyc = tc + 2;
    @(negedge clock);
    bus_if.req_valid = 1'b0;
  endtask

  always @(negedge clock) begin
    if (bus_if.rsp_valid) rsp_seen++;
    if (checking && cyc < NCYC) begin
      n_vec++;
      if ({bus_if.cmd, bus_if.cmd_bg, bus_if.cmd_bank, bus_if.cmd_row, bus_if.cmd_col,
           bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_write} !==
          {e_cmd[cyc], e_bg[cyc], e_bank[cyc], e_row[cyc], e_col[cyc],
           e_rdy[cyc], e_rsp[cyc], e_rspw[cyc]}) begin
        n_bad++;
        $display("FAIL cycle %0d outputs: got cmd=%0d bg=%0d bk=%0d row=%h col=%h rdy=%b rsp=%b rw=%b, expected cmd=%0d bg=%0d bk=%0d row=%h col=%h rdy=%b rsp=%b rw=%b",
                 cyc, bus_if.cmd, bus_if.cmd_bg, bus_if.cmd_bank, bus_if.cmd_row, bus_if.cmd_col,
                 bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_write,
                 e_cmd[cyc], e_bg[cyc], e_bank[cyc], e_row[cyc], e_col[cyc],
                 e_rdy[cyc], e_rsp[cyc], e_rspw[cyc]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, tp, ta, tc, c1, c4, c5, c7, c8, s;
    bus_if.req_valid = 1'b0; bus_if.req_bg = 3'd0; bus_if.req_bank = 2'd0;
    bus_if.req_row = 16'd0; bus_if.req_col = 10'd0; bus_if.req_write = 1'b0;
    clear_from(0);
    model_reset();
    repeat (3) @(negedge clock);
    check_lit("reset_ready", int'(bus_if.req_ready), 1);
    check_lit("reset_cmd", int'(bus_if.cmd), 0);
    check_lit("reset_rsp", int'({bus_if.rsp_valid, bus_if.rsp_write}), 0);
    check_lit("reset_addr", int'({bus_if.cmd_bg, bus_if.cmd_bank, bus_if.cmd_row, bus_if.cmd_col} != 0), 0);
    reset_n = 1'b1;
    free_cyc = cyc;
    checking = 1'b1;

    // closed-bank read
    submit(3'd1, 2'd2, 16'h00A5, 10'h013, 1'b0, t, tp, ta, tc);
    check_lit("r1_act0", ta - t, 1);
    check_lit("r1_rd0", tc - t, 9);
    c1 = tc;
    // row hit, same bank group
    submit(3'd1, 2'd2, 16'h00A5, 10'h014, 1'b0, t, tp, ta, tc);
    check_lit("r2_accept", t - c1, 2);
    check_lit("r2_rd0_gap", tc - c1, TCCD_L);
    check_lit("r2_no_act", ta, -1);
    // row miss write
    submit(3'd1, 2'd2, 16'h00A6, 10'h020, 1'b1, t, tp, ta, tc);
    check_lit("r3_pre", tp - t, 2);
    check_lit("r3_act0", ta - t, 10);
    check_lit("r3_wr0", tc - t, 18);
    // bg0 closed then hit
    submit(3'd0, 2'd0, 16'h1234, 10'h3FF, 1'b0, t, tp, ta, tc);
    c4 = tc;
    submit(3'd0, 2'd0, 16'h1234, 10'h001, 1'b0, t, tp, ta, tc);
    c5 = tc;
    check_lit("r5_tccd_l", c5 - c4, TCCD_L);
    // hit in another bank group
    submit(3'd1, 2'd2, 16'h00A6, 10'h2AA, 1'b0, t, tp, ta, tc);
    check_lit("r6_tccd_s", tc - c5, TCCD_S);
    // bg7 closed write, hit write, miss read bound by write recovery
    submit(3'd7, 2'd3, 16'hFFFF, 10'h155, 1'b1, t, tp, ta, tc);
    c7 = tc;
    submit(3'd7, 2'd3, 16'hFFFF, 10'h156, 1'b1, t, tp, ta, tc);
    c8 = tc;
    check_lit("r8_tccd_l", c8 - c7, TCCD_L);
    submit(3'd7, 2'd3, 16'h0001, 10'h000, 1'b0, t, tp, ta, tc);
    check_lit("r9_pre_twrp", tp - c8, TWRP);

    // idle window
    while (cyc < free_cyc) @(negedge clock);
    s = rsp_seen;
    repeat (50) @(negedge clock);
    check_lit("idle_rsp", rsp_seen - s, 0);

    // reset while waiting in CAS0
    submit(3'd4, 2'd1, 16'h0007, 10'h011, 1'b0, t, tp, ta, tc);
    while (cyc < t + 5) @(negedge clock);
    @(posedge clock);
    #2;
    clear_from(cyc);
    reset_n = 1'b0;
    #1;
    check_lit("midrst_cmd", int'(bus_if.cmd), 0);
    check_lit("midrst_ready", int'(bus_if.req_ready), 1);
    model_reset();
    free_cyc = cyc;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    submit(3'd4, 2'd1, 16'h0007, 10'h011, 1'b0, t, tp, ta, tc);
    check_lit("postrst_act0", ta - t, 1);
    check_lit("postrst_no_pre", tp, -1);

    while (cyc < free_cyc + 3) @(negedge clock);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ddr5_bank_sequencer.md
# ddr5_bank_sequencer

In-order DDR5 command sequencer for a single channel. It sits between the request queue (one decoded `queue_structure` entry at a time) and the command bus. It tracks open-row state and per-bank/per-bank-group timing for 32 banks (8 bank groups × 4 banks). It expands each read or write request into the PRE / ACT0-ACT1 / RD0-RD1 or WR0-WR1 command sequence, spacing commands by the timing parameters.

## Interface
- `TRCD`, 8: ACT0 to CAS0 of the same bank (cycles).
- `TRP`, 8: PRE to ACT0 of the same bank.
- `TRAS`, 16: ACT0 to PRE of the same bank.
- `TRTP`, 4: RD0 to PRE of the same bank.
- `TWRP`, 12: WR0 to PRE of the same bank.
- `TRRD_L`, 4: ACT0 to ACT0 in the same bank group.
- `TRRD_S`, 2: ACT0 to ACT0 in a different bank group.
- `TCCD_L`, 6: CAS0 to CAS0 in the same bank group.
- `TCCD_S`, 4: CAS0 to CAS0 in a different bank group.
- All parameters are 2..255.

Ports:
- `clock` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the sequencer is idle and can accept.
- `req_bg` in 3, `req_bank` in 2, `req_row` in 16, `req_col` in 10: decoded address. `req_col` is {col_high, col_low}.
- `req_write` in 1: 1 = write, 0 = data or instruction read.
- `cmd` out 4: command encoding. NULL=0, ACT0=1, ACT1=2, RD0=3, RD1=4, WR0=5, WR1=6, PRE=7.
- `cmd_bg` out 3, `cmd_bank` out 2, `cmd_row` out 16, `cmd_col` out 10: command address.
- `rsp_valid` out 1: one-cycle pulse when the request's CAS1 is issued.
- `rsp_write` out 1: the write flag of the completed request.

## Operation
- **Bank table**, one entry per bank:
  - `open`, `open_row`.
  - Down-counters `rcd_cnt`, `rp_cnt`, `pre_cnt`. Each decrements to 0 and saturates there.
- **Global history:**
  - `last_act_bg` and `act_elapsed` (8-bit, saturating at 255).
  - `last_cas_bg` and `cas_elapsed` (8-bit, saturating at 255).
- **FSM states:** IDLE, PRE, ACT0, ACT1, CAS0, CAS1.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, latch the request.
  - Next state from the bank table: row hit → CAS0; bank open with another row → PRE; bank closed → ACT0.
- **PRE:**
  - Issue PRE when `pre_cnt`==0.
  - On issue: `open`=0, `rp_cnt`=TRP-1. Then go to ACT0.
- **ACT0:**
  - Issue when `rp_cnt`==0 and `act_elapsed` ≥ (bg==`last_act_bg` ? TRRD_L : TRRD_S).
  - On issue: `open`=1, `open_row`=row, `rcd_cnt`=TRCD-1, `pre_cnt`=max(`pre_cnt`, TRAS-1), `act_elapsed`=0, `last_act_bg`=bg.
- **ACT1:** issued unconditionally on the next cycle.
- **CAS0:**
  - Issue RD0 or WR0 when `rcd_cnt`==0 and `cas_elapsed` ≥ (bg==`last_cas_bg` ? TCCD_L : TCCD_S).
  - On issue: `pre_cnt`=max(`pre_cnt`, (write ? TWRP : TRTP)-1), `cas_elapsed`=0, `last_cas_bg`=bg.
- **CAS1:**
  - Issue RD1 or WR1 with `rsp_valid`=1. Then return to IDLE.
- **Command fields:**
  - `cmd`=NULL (0) on any cycle where nothing is issued. Address outputs are 0 on NULL cycles.
  - ACT0/ACT1 carry bg/bank/row, with col=0.
  - CAS commands carry bg/bank/col, with row=0.
  - PRE carries bg/bank only.
- **Timing rule:** a constraint N between commands at cycle t means the dependent command is issued no earlier than t+N. The counter is loaded with N-1 on the issue cycle.
- **Counters and history:** all counters and elapsed trackers update every cycle, independent of FSM state. Timers for other banks continue to run while waiting.
- **Reset** (asynchronous, at any point including mid-sequence):
  - All banks closed; all counters 0.
  - `act_elapsed` and `cas_elapsed` = 255; `last_*_bg` = 0.
  - FSM in IDLE; the in-flight request is dropped.
  - Outputs: `req_ready`=1, `cmd`=0, all address outputs 0, `rsp_valid`=0, `rsp_write`=0.

## Timing
- Request accepted at cycle t; the first command is eligible at t+1.
- `req_ready` is 0 from t+1 through the CAS1 cycle, and 1 again on the cycle after CAS1.
- Closed bank with no pending constraints: ACT0 at t+1, CAS0 at t+1+TRCD, response at t+2+TRCD.
- Row hit with no pending constraints: CAS0 at t+1, response at t+2.
- At most one command per cycle. ACTx and CASx pairs always occupy consecutive cycles.

## Test plan
- **Closed-bank read.** Reset; read bg1/bank2/row 0x00A5/col 0x013 accepted at cycle 0 → ACT0 @1, ACT1 @2, RD0 @9, RD1 @10, `rsp_valid` @10, `req_ready` @11.
- **Row hit, same bank.** Read accepted @11 → RD0 @15 (TCCD_L from the RD0 @9), RD1 @16.
- **Row miss, write.** Same bank, row 0x00A6, accepted @17 → PRE @19 (TRTP bound, later than TRAS @17), ACT0 @27, WR0 @35, WR1 @36, `rsp_write`=1.
- **Different bank groups.** Back-to-back closed-bank reads to bg0 then bg1 → ACT0s 2 cycles apart at minimum (TRRD_S). Same BG → ≥4 apart. CAS0s ≥4 apart.
- **Reset mid-operation.** Assert `reset_n`=0 while waiting in CAS0 → `cmd`=0 and `req_ready`=1 immediately. After release, the same request to the same row issues ACT0 first, because the bank was closed by reset.
- **Idle.** `req_valid`=0 for 50 cycles → `cmd` stays 0 and no `rsp_valid` pulses occur.
